// File: rtl/tile_drain_streamer.sv
// Scans every tile of a binned frame in ascending order, streams its stored points
// with tile/first/last tags over valid/ready, then clears the drained tile's count.
module tile_drain_streamer #(
   parameter int NUM_TILES    = 256,
   parameter int TILE_W       = 8,
   parameter int PTS_PER_TILE = 32,
   parameter int SLOT_W       = 5,
   parameter int CNT_W        = 6,
   parameter int POINT_W      = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic [TILE_W-1:0]  cnt_rd_idx,
   input  logic [CNT_W-1:0]   cnt_rd_data,
   output logic               pt_rd_en,
   output logic [TILE_W-1:0]  pt_rd_tile,
   output logic [SLOT_W-1:0]  pt_rd_slot,
   input  logic [POINT_W-1:0] pt_rd_data,
   output logic               clr_en,
   output logic [TILE_W-1:0]  clr_idx,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [POINT_W-1:0] out_point,
   output logic [TILE_W-1:0]  out_tile,
   output logic               out_first,
   output logic               out_last,
   output logic [15:0]        pts_emitted,
   output logic [TILE_W:0]    tiles_nonempty
);

   typedef enum logic [2:0] {
      S_IDLE, S_CNT_RD, S_CNT_CHK, S_PT_RD, S_PT_HOLD, S_CLR, S_DONE
   } state_t;

   localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(PTS_PER_TILE);
   localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

   state_t               state_q, state_d;
   logic [TILE_W-1:0]    tile_q, tile_d;
   logic [SLOT_W-1:0]    slot_q, slot_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 pt_rd_en_q, pt_rd_en_d;
   logic                 clr_en_q, clr_en_d;
   logic                 out_valid_q, out_valid_d;
   logic                 out_first_q, out_first_d;
   logic                 out_last_q, out_last_d;
   logic                 hold_first_q, hold_first_d;
   logic [POINT_W-1:0]   point_q, point_d;
   logic [15:0]          pts_emitted_q, pts_emitted_d;
   logic [TILE_W:0]      tiles_nonempty_q, tiles_nonempty_d;
   logic                 handshake;
   logic                 adv_tile;

   function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] raw);
      return (raw > MAX_CNT) ? MAX_CNT : raw;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign handshake = out_valid_q & out_ready;

   always_comb begin
      state_d          = state_q;
      tile_d           = tile_q;
      slot_d           = slot_q;
      cnt_d            = cnt_q;
      busy_d           = busy_q;
      done_d           = 1'b0;
      pt_rd_en_d       = 1'b0;
      clr_en_d         = 1'b0;
      out_valid_d      = out_valid_q;
      out_first_d      = out_first_q;
      out_last_d       = out_last_q;
      hold_first_d     = 1'b0;
      point_d          = point_q;
      pts_emitted_d    = pts_emitted_q;
      tiles_nonempty_d = tiles_nonempty_q;
      adv_tile         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               tile_d           = '0;
               pts_emitted_d    = '0;
               tiles_nonempty_d = '0;
               busy_d           = 1'b1;
               state_d          = S_CNT_RD;
            end
         end
         S_CNT_RD: state_d = S_CNT_CHK;
         S_CNT_CHK: begin
            cnt_d = clamp_cnt(cnt_rd_data);
            if (clamp_cnt(cnt_rd_data) == '0) begin
               adv_tile = 1'b1;
            end else begin
               slot_d           = '0;
               tiles_nonempty_d = tiles_nonempty_q + (TILE_W+1)'(1);
               pt_rd_en_d       = 1'b1;
               state_d          = S_PT_RD;
            end
         end
         S_PT_RD: begin
            out_valid_d  = 1'b1;
            hold_first_d = 1'b1;
            out_first_d  = (slot_q == '0);
            out_last_d   = ((CNT_W'(slot_q) + CNT_W'(1)) == cnt_q);
            state_d      = S_PT_HOLD;
         end
         S_PT_HOLD: begin
            if (hold_first_q) point_d = pt_rd_data;
            if (handshake) begin
               out_valid_d   = 1'b0;
               pts_emitted_d = sat_inc16(pts_emitted_q);
               if (out_last_q) begin
                  clr_en_d = 1'b1;
                  state_d  = S_CLR;
               end else begin
                  slot_d     = slot_q + SLOT_W'(1);
                  pt_rd_en_d = 1'b1;
                  state_d    = S_PT_RD;
               end
            end
         end
         S_CLR:  adv_tile = 1'b1;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (adv_tile) begin
         if (tile_q == LAST_TILE) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
         end else begin
            tile_d  = tile_q + TILE_W'(1);
            state_d = S_CNT_RD;
         end
      end

      // A beat accepted in the abort cycle still counts; everything else is dropped.
      if (abort && (state_q != S_IDLE)) begin
         state_d          = S_IDLE;
         busy_d           = 1'b0;
         done_d           = 1'b0;
         clr_en_d         = 1'b0;
         pt_rd_en_d       = 1'b0;
         out_valid_d      = 1'b0;
         hold_first_d     = 1'b0;
         tiles_nonempty_d = tiles_nonempty_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= S_IDLE;
         tile_q           <= '0;
         slot_q           <= '0;
         cnt_q            <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         pt_rd_en_q       <= 1'b0;
         clr_en_q         <= 1'b0;
         out_valid_q      <= 1'b0;
         out_first_q      <= 1'b0;
         out_last_q       <= 1'b0;
         hold_first_q     <= 1'b0;
         point_q          <= '0;
         pts_emitted_q    <= '0;
         tiles_nonempty_q <= '0;
      end else begin
         state_q          <= state_d;
         tile_q           <= tile_d;
         slot_q           <= slot_d;
         cnt_q            <= cnt_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         pt_rd_en_q       <= pt_rd_en_d;
         clr_en_q         <= clr_en_d;
         out_valid_q      <= out_valid_d;
         out_first_q      <= out_first_d;
         out_last_q       <= out_last_d;
         hold_first_q     <= hold_first_d;
         point_q          <= point_d;
         pts_emitted_q    <= pts_emitted_d;
         tiles_nonempty_q <= tiles_nonempty_d;
      end
   end

   // The point RAM output is already a register; forward it on the first hold
   // cycle so a beat costs two cycles, then present the captured copy while stalled.
   assign out_point      = hold_first_q ? pt_rd_data : point_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign cnt_rd_idx     = tile_q;
   assign pt_rd_en       = pt_rd_en_q;
   assign pt_rd_tile     = tile_q;
   assign pt_rd_slot     = slot_q;
   assign clr_en         = clr_en_q;
   assign clr_idx        = tile_q;
   assign out_valid      = out_valid_q;
   assign out_tile       = tile_q;
   assign out_first      = out_first_q;
   assign out_last       = out_last_q;
   assign pts_emitted    = pts_emitted_q;
   assign tiles_nonempty = tiles_nonempty_q;

endmodule
